// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported synchronous memory.
// One request in flight at a time: IDLE -> ACCESS (one memory strobe) -> RESP.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] i_rsp_rdata,
  output logic        i_rsp_err,

  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wenable,
  output logic        mem_renable,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 32'd4);

  state_t      state, state_next;
  logic        last_grant;   // 1 = data was granted most recently
  logic        cap_id;       // 1 = data requester owns the transaction
  logic        cap_we;
  logic        cap_err;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        rsp_first;
  logic [31:0] rsp_rdata_q;

  logic        grant_i, grant_d, accept;
  logic [31:0] sel_addr;
  logic        sel_legal;
  logic        mem_access, in_resp, rsp_hs;
  logic [31:0] rsp_live, rsp_rdata;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    // Ready is gated by rst so that every output is 0 while reset is held.
    if (rst && state == IDLE) begin
      if (i_req_valid && d_req_valid) begin
        grant_i = last_grant;
        grant_d = !last_grant;
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;
  assign accept      = grant_i | grant_d;
  assign sel_addr    = grant_d ? d_req_addr : i_req_addr;
  assign sel_legal   = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_ADDR);
  assign in_resp     = (state == RESP);
  assign rsp_hs      = in_resp && (cap_id ? d_rsp_ready : i_rsp_ready);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cap_id      <= 1'b0;
      cap_we      <= 1'b0;
      cap_err     <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      rsp_first   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state     <= state_next;
      rsp_first <= (state == ACCESS);
      if (accept) begin
        last_grant <= grant_d;
        cap_id     <= grant_d;
        cap_addr   <= sel_addr;
        cap_we     <= grant_d & d_req_we;
        cap_wdata  <= grant_d ? d_req_wdata : '0;
        cap_err    <= !sel_legal;
      end
      if (in_resp && rsp_first) rsp_rdata_q <= rsp_live;
    end
  end

  assign mem_access  = (state == ACCESS) && !cap_err;
  assign mem_addr    = mem_access ? cap_addr : '0;
  assign mem_wdata   = mem_access ? cap_wdata : '0;
  assign mem_wenable = mem_access && cap_we;
  assign mem_renable = mem_access && !cap_we;

  // The memory's output register only holds the read word from the first RESP
  // cycle on, so that cycle forwards it and the copy taken then is held afterwards.
  assign rsp_live  = (!cap_err && !cap_we) ? mem_rdata : '0;
  assign rsp_rdata = rsp_first ? rsp_live : rsp_rdata_q;

  assign i_rsp_valid = in_resp && !cap_id;
  assign i_rsp_rdata = i_rsp_valid ? rsp_rdata : '0;
  assign i_rsp_err   = i_rsp_valid && cap_err;
  assign d_rsp_valid = in_resp && cap_id;
  assign d_rsp_rdata = d_rsp_valid ? rsp_rdata : '0;
  assign d_rsp_err   = d_rsp_valid && cap_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations
// plus randomized two-requester traffic compared against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int          WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0, i_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_rsp_valid, i_rsp_ready = 1'b0, i_rsp_err;
  logic [31:0] i_rsp_rdata;
  logic        d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0;
  logic        d_rsp_valid, d_rsp_ready = 1'b0, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wenable, mem_renable;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata),
    .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
    .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .mem_renable(mem_renable), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  logic [7:0] ctrl;
  assign ctrl = {i_req_ready, i_rsp_valid, i_rsp_err, d_req_ready,
                 d_rsp_valid, d_rsp_err, mem_wenable, mem_renable};

  // Attached memory: registered read, one write port.
  logic [31:0] init_img [WORDS];
  logic [31:0] ram [WORDS];
  logic        ram_loaded = 1'b0;
  int unsigned mem_idx;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < WORDS; k++) ram[k] <= init_img[k];
      ram_loaded <= 1'b1;
    end else begin
      mem_idx = mem_addr >> 2;
      if (mem_wenable && mem_idx < WORDS) ram[mem_idx] <= mem_wdata;
      if (mem_renable && mem_idx < WORDS) mem_rdata <= ram[mem_idx];
    end
  end

  // Reference model: one outstanding transaction, outcome computed at acceptance.
  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        legal;
    logic [31:0] rdata;
  } txn_t;

  txn_t        cur;
  bit          busy, strobed, m_last, ref_loaded;
  logic [31:0] ref_mem [WORDS];

  function automatic bit is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(MEM_BYTES - 4));
  endfunction

  // Returns {data_granted, fetch_granted}; lg=1 means data won last time.
  function automatic logic [1:0] pick(input logic iv, input logic dv, input bit lg);
    if (iv && dv) return lg ? 2'b01 : 2'b10;
    return {dv, iv};
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [1:0]  g;
    logic [31:0] a;
    if (!rst) begin
      if (!ref_loaded) begin
        for (int k = 0; k < WORDS; k++) ref_mem[k] <= init_img[k];
        ref_loaded <= 1'b1;
      end
      busy    <= 1'b0;
      strobed <= 1'b0;
      m_last  <= 1'b1;
    end else if (busy && !strobed) begin
      strobed <= 1'b1;
    end else if (busy) begin
      if (cur.id ? d_rsp_ready : i_rsp_ready) busy <= 1'b0;
    end else begin
      g = pick(i_req_valid, d_req_valid, m_last);
      if (g != 2'b00) begin
        a = g[1] ? d_req_addr : i_req_addr;
        cur.id    <= g[1];
        cur.addr  <= a;
        cur.we    <= g[1] & d_req_we;
        cur.wdata <= g[1] ? d_req_wdata : 32'd0;
        cur.legal <= is_legal(a);
        cur.rdata <= (is_legal(a) && !(g[1] & d_req_we)) ? ref_mem[a >> 2] : 32'd0;
        if (is_legal(a) && g[1] && d_req_we) ref_mem[a >> 2] <= d_req_wdata;
        busy    <= 1'b1;
        strobed <= 1'b0;
        m_last  <= g[1];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] g;
    logic [7:0] e;
    if (ref_loaded) begin
      if (!rst) begin
        check("reset_ctrl", {24'd0, ctrl}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_i_rdata", i_rsp_rdata, 32'd0);
        check("reset_d_rdata", d_rsp_rdata, 32'd0);
      end else if (!busy) begin
        g = pick(i_req_valid, d_req_valid, m_last);
        e = {g[0], 2'b00, g[1], 4'b0000};
        check("idle_ctrl", {24'd0, ctrl}, {24'd0, e});
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_mem_wdata", mem_wdata, 32'd0);
      end else if (!strobed) begin
        e = {6'b000000, cur.legal & cur.we, cur.legal & ~cur.we};
        check("access_ctrl", {24'd0, ctrl}, {24'd0, e});
        if (cur.legal) begin
          check("access_mem_addr", mem_addr, cur.addr);
          check("access_mem_wdata", mem_wdata, cur.wdata);
        end
      end else begin
        e = {1'b0, ~cur.id, ~cur.id & ~cur.legal, 1'b0, cur.id, cur.id & ~cur.legal, 2'b00};
        check("resp_ctrl", {24'd0, ctrl}, {24'd0, e});
        check("resp_rdata", cur.id ? d_rsp_rdata : i_rsp_rdata, cur.rdata);
        check("resp_mem_addr", mem_addr, 32'd0);
      end
    end
  end

  // Issue one request with rsp_ready held high and return its response.
  task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int waited);
    bit legal;
    legal = is_legal(addr);
    i_rsp_ready = 1'b1;
    d_rsp_ready = 1'b1;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    #1;
    waited = 0;
    while (!(is_d ? d_req_ready : i_req_ready) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check1("req_ready", is_d ? d_req_ready : i_req_ready, 1'b1);
    @(posedge clk); #1;
    if (is_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
    @(negedge clk);
    check("strobe_cycle", {30'd0, mem_wenable, mem_renable},
          legal ? (we ? 32'd2 : 32'd1) : 32'd0);
    if (legal) check("strobe_addr", mem_addr, addr);
    @(negedge clk);
    check1("rsp_cycle_valid", is_d ? d_rsp_valid : i_rsp_valid, 1'b1);
    rdata = is_d ? d_rsp_rdata : i_rsp_rdata;
    err   = is_d ? d_rsp_err : i_rsp_err;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = 32'(MEM_BYTES - 4);
      2:       a = 32'(MEM_BYTES);
      3:       a = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
      default: a = 32'($urandom_range(0, WORDS - 1)) << 2;
    endcase
    return a;
  endfunction

  task automatic drive_fetch(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1; i_req_valid = 1'b1; i_req_addr = rand_addr();
      #1; w = 0;
      while (!i_req_ready && w < 200) begin @(negedge clk); w++; end
      check1("rand_fetch_accept", i_req_ready, 1'b1);
      @(posedge clk); #1; i_req_valid = 1'b0;
    end
  endtask

  task automatic drive_data(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1; d_req_valid = 1'b1; d_req_addr = rand_addr();
      d_req_we = 1'($urandom_range(0, 1)); d_req_wdata = $urandom;
      #1; w = 0;
      while (!d_req_ready && w < 200) begin @(negedge clk); w++; end
      check1("rand_data_accept", d_req_ready, 1'b1);
      @(posedge clk); #1; d_req_valid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          waited, n, done, guard;
    int          order[$];

    for (int k = 0; k < WORDS; k++) init_img[k] = $urandom;
    init_img[4]   = 32'hDEADBEEF;
    init_img[255] = 32'hCAFEF00D;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Fetch read right after reset: accepted at the first edge.
    do_req(1'b0, 1'b0, 32'h10, 32'd0, rd, er, waited);
    check("first_accept_wait", waited, 0);
    check("fetch_0x10_rdata", rd, 32'hDEADBEEF);
    check1("fetch_0x10_err", er, 1'b0);

    // Data write then read back.
    do_req(1'b1, 1'b1, 32'h20, 32'h12345678, rd, er, waited);
    check("write_rdata", rd, 32'd0);
    check1("write_err", er, 1'b0);
    do_req(1'b1, 1'b0, 32'h20, 32'd0, rd, er, waited);
    check("readback_rdata", rd, 32'h12345678);

    // Illegal addresses and the last legal word.
    do_req(1'b1, 1'b0, 32'h22, 32'd0, rd, er, waited);
    check1("unaligned_err", er, 1'b1);
    check("unaligned_rdata", rd, 32'd0);
    do_req(1'b0, 1'b0, 32'h400, 32'd0, rd, er, waited);
    check1("oob_err", er, 1'b1);
    check("oob_rdata", rd, 32'd0);
    do_req(1'b0, 1'b0, 32'h3FC, 32'd0, rd, er, waited);
    check1("last_word_err", er, 1'b0);
    check("last_word_rdata", rd, 32'hCAFEF00D);
    do_req(1'b1, 1'b1, 32'hFFFFFFFC, 32'h55AA55AA, rd, er, waited);
    check1("high_addr_write_err", er, 1'b1);

    // Round robin with both requesters valid from reset.
    @(negedge clk); #2 rst = 1'b0;
    i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h44;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 n = 0;
    while (order.size() < 4 && n < 40) begin
      if (i_req_ready) order.push_back(0);
      if (d_req_ready) order.push_back(1);
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rr_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      check($sformatf("rr_grant%0d", k), order[k], k % 2);

    // Data response stalled while fetch waits.
    d_rsp_ready = 1'b0; i_rsp_ready = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h10;
    #1 check1("stall_d_accept", d_req_ready, 1'b1);
    @(posedge clk); #1;
    d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h14;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check1("stall_d_valid", d_rsp_valid, 1'b1);
      check("stall_d_rdata", d_rsp_rdata, 32'hDEADBEEF);
      check1("stall_d_err", d_rsp_err, 1'b0);
      check1("stall_i_ready", i_req_ready, 1'b0);
      if (k < 5) @(negedge clk);
    end
    @(posedge clk); #1 d_rsp_ready = 1'b1;
    @(negedge clk);
    check1("stall_release_valid", d_rsp_valid, 1'b1);
    @(negedge clk);
    check1("stall_fetch_ready", i_req_ready, 1'b1);
    check1("stall_d_done", d_rsp_valid, 1'b0);
    @(posedge clk); #1 i_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during the strobe cycle of a write (rewrites the value already held).
    d_rsp_ready = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h30; d_req_wdata = ref_mem[12];
    #1 check1("rst_test_accept", d_req_ready, 1'b1);
    @(posedge clk); #1 d_req_valid = 1'b0;
    @(negedge clk);
    check1("rst_test_wen", mem_wenable, 1'b1);
    #2 rst = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h10;
    #1;
    check("rst_async_ctrl", {24'd0, ctrl}, 32'd0);
    check("rst_async_mem_addr", mem_addr, 32'd0);
    check("rst_async_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check1("after_rst_d_ready", d_req_ready, 1'b1);
    check1("after_rst_no_rsp", d_rsp_valid, 1'b0);
    @(posedge clk); #1 d_req_valid = 1'b0;
    @(negedge clk);
    check1("after_rst_ren", mem_renable, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Randomized concurrent traffic.
    done = 0;
    guard = 0;
    fork
      begin drive_fetch(150); done++; end
      begin drive_data(150); done++; end
      begin
        while (done < 2 && guard < 20000) begin
          @(posedge clk); #1;
          i_rsp_ready = ($urandom_range(0, 3) != 0);
          d_rsp_ready = ($urandom_range(0, 3) != 0);
          guard++;
        end
      end
    join
    i_rsp_ready = 1'b1;
    d_rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
